// File: rtl/trip_thermal_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trip_thermal_supervisor                                         |
// | Purpose  : Debounced CPU thermal shutdown with cooldown, plus trip         |
// |            sequencing that gates the drive command on computer power.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module trip_thermal_supervisor #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int COOLDOWN_CYC = 16,
    parameter int EVT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trip_start,
    input  logic             cpu_overheated,
    input  logic             arrived,
    input  logic             gas_tank_empty,
    output logic             shut_off_computer,
    output logic             keep_driving,
    output logic [1:0]       drive_state,
    output logic             trip_done,
    output logic [EVT_W-1:0] overheat_events
);

    localparam int c_cnt_max = (DEBOUNCE_CYC > COOLDOWN_CYC) ? DEBOUNCE_CYC : COOLDOWN_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cool_last = c_cnt_w'(COOLDOWN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        T_RUN      = 2'd0,
        T_SHUTDOWN = 2'd1,
        T_COOLDOWN = 2'd2
    } therm_t;

    typedef enum logic [1:0] {
        D_PARKED  = 2'd0,
        D_DRIVING = 2'd1,
        D_REFUEL  = 2'd2,
        D_ARRIVED = 2'd3
    } drive_t;

    therm_t             r_therm;
    therm_t             w_therm_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_trip;

    drive_t             r_drive;
    drive_t             w_drive_nxt;

    logic               r_shut;
    logic               r_keep;
    logic [EVT_W-1:0]   r_evt;
    logic               w_shut_nxt;
    logic               w_keep_nxt;
    logic [EVT_W-1:0]   w_evt_nxt;

    // Thermal next state: the shared counter debounces in T_RUN and times the cooldown
    always_comb begin
        w_therm_nxt = r_therm;
        w_cnt_nxt   = r_cnt;
        w_trip      = 1'b0;
        case (r_therm)
            T_RUN: begin
                if (cpu_overheated) begin
                    if (r_cnt == c_deb_last) begin
                        w_therm_nxt = T_SHUTDOWN;
                        w_cnt_nxt   = '0;
                        w_trip      = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            T_SHUTDOWN: begin
                if (!cpu_overheated) begin
                    // A single-cycle cooldown completes on the first cool sample
                    if (COOLDOWN_CYC == 1) begin
                        w_therm_nxt = T_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_therm_nxt = T_COOLDOWN;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            T_COOLDOWN: begin
                if (cpu_overheated) begin
                    w_therm_nxt = T_SHUTDOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cool_last) begin
                    w_therm_nxt = T_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_therm_nxt = T_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Drive next state; thermal shutdown never alters it, only gates keep_driving
    always_comb begin
        w_drive_nxt = r_drive;
        case (r_drive)
            D_PARKED: begin
                if (trip_start && !arrived)
                    w_drive_nxt = gas_tank_empty ? D_REFUEL : D_DRIVING;
            end
            D_DRIVING: begin
                if (arrived)
                    w_drive_nxt = D_ARRIVED;
                else if (gas_tank_empty)
                    w_drive_nxt = D_REFUEL;
            end
            D_REFUEL: begin
                if (arrived)
                    w_drive_nxt = D_ARRIVED;
                else if (!gas_tank_empty)
                    w_drive_nxt = D_DRIVING;
            end
            D_ARRIVED: w_drive_nxt = D_PARKED;
            default:   w_drive_nxt = D_PARKED;
        endcase
    end

    always_comb begin
        w_shut_nxt = (w_therm_nxt != T_RUN);
        w_keep_nxt = (w_drive_nxt == D_DRIVING) && !w_shut_nxt;
        w_evt_nxt  = r_evt;
        if (w_trip && (r_evt != {EVT_W{1'b1}}))
            w_evt_nxt = r_evt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_therm <= T_RUN;
            r_cnt   <= '0;
            r_drive <= D_PARKED;
            r_shut  <= 1'b0;
            r_keep  <= 1'b0;
            r_evt   <= '0;
        end else begin
            r_therm <= w_therm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drive <= w_drive_nxt;
            r_shut  <= w_shut_nxt;
            r_keep  <= w_keep_nxt;
            r_evt   <= w_evt_nxt;
        end
    end

    assign shut_off_computer = r_shut;
    assign keep_driving      = r_keep;
    assign drive_state       = r_drive;
    assign trip_done         = (r_drive == D_ARRIVED);
    assign overheat_events   = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_trip_thermal_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_trip_thermal_supervisor                                      |
// | Purpose  : Directed vector bench for trip_thermal_supervisor.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_trip_thermal_supervisor;

    logic       clk;
    logic       rst_n;
    logic       trip_start;
    logic       cpu_overheated;
    logic       arrived;
    logic       gas_tank_empty;
    logic       shut_off_computer;
    logic       keep_driving;
    logic [1:0] drive_state;
    logic       trip_done;
    logic [7:0] overheat_events;

    logic       sat_overheated;
    logic       sat_shut;
    logic       sat_keep;
    logic [1:0] sat_state;
    logic       sat_done;
    logic [1:0] sat_events;

    int n_pass;
    int n_total;

    trip_thermal_supervisor #(
        .DEBOUNCE_CYC(4),
        .COOLDOWN_CYC(16),
        .EVT_W       (8)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trip_start       (trip_start),
        .cpu_overheated   (cpu_overheated),
        .arrived          (arrived),
        .gas_tank_empty   (gas_tank_empty),
        .shut_off_computer(shut_off_computer),
        .keep_driving     (keep_driving),
        .drive_state      (drive_state),
        .trip_done        (trip_done),
        .overheat_events  (overheat_events)
    );

    trip_thermal_supervisor #(
        .DEBOUNCE_CYC(1),
        .COOLDOWN_CYC(1),
        .EVT_W       (2)
    ) u_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .trip_start       (trip_start),
        .cpu_overheated   (sat_overheated),
        .arrived          (arrived),
        .gas_tank_empty   (gas_tank_empty),
        .shut_off_computer(sat_shut),
        .keep_driving     (sat_keep),
        .drive_state      (sat_state),
        .trip_done        (sat_done),
        .overheat_events  (sat_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ts;
        logic       ovh;
        logic       arr;
        logic       gas;
        logic       shut;
        logic       keep;
        logic [1:0] st;
        logic       done;
        logic [7:0] evt;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_all(input string nm, input logic shut, input logic keep,
                           input logic [1:0] st, input logic done, input logic [7:0] evt);
        chk({nm, ".shut"}, {31'd0, shut_off_computer}, {31'd0, shut});
        chk({nm, ".keep"}, {31'd0, keep_driving}, {31'd0, keep});
        chk({nm, ".state"}, {30'd0, drive_state}, {30'd0, st});
        chk({nm, ".done"}, {31'd0, trip_done}, {31'd0, done});
        chk({nm, ".events"}, {24'd0, overheat_events}, {24'd0, evt});
    endtask

    task automatic step(input logic ts, input logic ovh, input logic arr, input logic gas);
        trip_start     = ts;
        cpu_overheated = ovh;
        arrived        = arr;
        gas_tank_empty = gas;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        trip_start     = 1'b0;
        cpu_overheated = 1'b0;
        arrived        = 1'b0;
        gas_tank_empty = 1'b0;
        sat_overheated = 1'b0;
        rst_n          = 1'b1;

        //            ts    ovh   arr   gas   shut  keep  st     done  evt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 8'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};

        #1 rst_n = 1'b0;
        #1;
        chk_all("reset", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Trip sequencing and drive priority
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].ts, vecs[i].ovh, vecs[i].arr, vecs[i].gas);
            chk_all($sformatf("vec%0d", i), vecs[i].shut, vecs[i].keep,
                    vecs[i].st, vecs[i].done, vecs[i].evt);
        end

        // Asynchronous reset while driving, applied between edges
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("pre_rst", 1'b0, 1'b1, 2'd1, 1'b0, 8'd0);
        #3 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Debounce while driving: 1,1,1,0 then 1,1,1,1
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("drive_go", 1'b0, 1'b1, 2'd1, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i != 3), 1'b0, 1'b0);
            if (i == 7) chk_all("deb_trip", 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
            else        chk_all($sformatf("deb%0d", i), 1'b0, 1'b1, 2'd1, 1'b0, 8'd0);
        end

        // Interrupted cooldown, then a full one
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk_all($sformatf("cool_a%0d", i), 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("reheat", 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 15) chk_all("cool_done", 1'b0, 1'b1, 2'd1, 1'b0, 8'd1);
            else         chk_all($sformatf("cool_b%0d", i), 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
        end

        // Arrive, then a thermal trip on the same edge as trip_start
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("arrive", 1'b0, 1'b0, 2'd3, 1'b1, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("parked", 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk_all($sformatf("sim_pre%0d", i), 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("sim_trip", 1'b1, 1'b0, 2'd1, 1'b0, 8'd2);

        // Saturation on the narrow counter instance
        for (int k = 1; k <= 5; k++) begin
            sat_overheated = 1'b1;
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("sat_shut_on%0d", k), {31'd0, sat_shut}, 32'd1);
            chk($sformatf("sat_evt%0d", k), {30'd0, sat_events}, (k > 3) ? 32'd3 : k);
            sat_overheated = 1'b0;
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("sat_shut_off%0d", k), {31'd0, sat_shut}, 32'd0);
        end
        chk("sat_hold", {30'd0, sat_events}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
